// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command/PWM path.
//   ANGLE_W / MAX_ANGLE / NUM_SERVO : angle width, mechanical limit, channel count
//   angle_t                         : one angle in degrees
//   slew_state_t                    : frame update sequencer states
//   clamp_angle()                   : saturate an angle to MAX_ANGLE
package servo_pkg;

    localparam int unsigned ANGLE_W   = 8;
    localparam int unsigned MAX_ANGLE = 180;
    localparam int unsigned NUM_SERVO = 4;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UPD0  = 3'd1,
        UPD1  = 3'd2,
        UPD2  = 3'd3,
        UPD3  = 3'd4,
        PULSE = 3'd5
    } slew_state_t;

    // Saturate a requested angle to the mechanical limit.
    function automatic angle_t clamp_angle(input angle_t a);
        return (a > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : a;
    endfunction

endpackage

// File: rtl/servo_slew_step.sv
// One slew step: move cur toward tgt by at most step, landing exactly on tgt
// when within reach (no overshoot, no wrap).
//   cur        : current angle
//   tgt        : target angle (already clamped to MAX_ANGLE)
//   step       : maximum change per step
//   next_angle : resulting angle
module servo_slew_step
    import servo_pkg::*;
(
    input  angle_t cur,
    input  angle_t tgt,
    input  angle_t step,
    output angle_t next_angle
);

    logic signed [ANGLE_W:0] diff;
    logic        [ANGLE_W:0] mag;

    always_comb begin
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        // Magnitude formed from the unsigned operands so -diff never overflows.
        mag  = diff[ANGLE_W] ? ({1'b0, cur} - {1'b0, tgt})
                             : ({1'b0, tgt} - {1'b0, cur});
        if (mag <= {1'b0, step}) begin
            next_angle = tgt;
        end else if (!diff[ANGLE_W]) begin
            next_angle = cur + step;
        end else begin
            next_angle = cur - step;
        end
    end

endmodule

// File: rtl/servo_angle_slew.sv
// Rate-limited angle command stage in front of the PWM servo driver.
// Accepts per-channel targets over a valid/ready port and, once per frame,
// slews each current angle toward its target by at most STEP degrees, then
// strobes nextangle so the PWM stage loads the new angles.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_valid/wr_ready  : target write handshake
//   wr_chan, wr_angle  : channel (0..3) and requested angle (clamped)
//   angle1..angle4     : current angles, straight from registers
//   nextangle          : one-cycle load strobe, once per frame
//   settled            : all current angles equal their targets
module servo_angle_slew
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned STEP         = 2,
    parameter int unsigned RESET_ANGLE  = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_chan,
    input  logic [7:0] wr_angle,
    output logic [7:0] angle1,
    output logic [7:0] angle2,
    output logic [7:0] angle3,
    output logic [7:0] angle4,
    output logic       nextangle,
    output logic       settled
);

    localparam int unsigned CNT_W   = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam angle_t      STEP_A  = angle_t'(STEP);
    localparam angle_t      RST_A   = angle_t'(RESET_ANGLE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc;

    slew_state_t state_q, state_d;
    logic        nextangle_q, nextangle_d;
    logic        wr_ready_q, wr_ready_d;
    logic        settled_q, settled_d;
    logic        upd_en;
    logic [1:0]  upd_idx;

    angle_t angle_q  [NUM_SERVO];
    angle_t angle_d  [NUM_SERVO];
    angle_t target_q [NUM_SERVO];
    angle_t target_d [NUM_SERVO];

    angle_t step_cur, step_tgt, step_next;
    logic   wr_accept;

    // Free-running frame counter; runs in every state so the strobe period is exact.
    always_comb begin
        tc    = (cnt_q == CNT_LAST);
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Frame sequencer: one update cycle per channel, then the load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nextangle_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nextangle_q <= nextangle_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nextangle_d = 1'b0;
        wr_ready_d  = 1'b0;
        upd_en      = 1'b0;
        upd_idx     = 2'd0;
        unique case (state_q)
            IDLE:  if (tc) state_d = UPD0;
            UPD0:  begin state_d = UPD1;  upd_en = 1'b1; upd_idx = 2'd0; end
            UPD1:  begin state_d = UPD2;  upd_en = 1'b1; upd_idx = 2'd1; end
            UPD2:  begin state_d = UPD3;  upd_en = 1'b1; upd_idx = 2'd2; end
            UPD3:  begin state_d = PULSE; upd_en = 1'b1; upd_idx = 2'd3; end
            PULSE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered outputs track the state being entered.
        nextangle_d = (state_d == PULSE);
        wr_ready_d  = (state_d == IDLE) || (state_d == PULSE);
    end

    // Single shared slew step, muxed across channels by the update state.
    assign step_cur = angle_q[upd_idx];
    assign step_tgt = target_q[upd_idx];

    servo_slew_step u_step (
        .cur        (step_cur),
        .tgt        (step_tgt),
        .step       (STEP_A),
        .next_angle (step_next)
    );

    assign wr_accept = wr_valid && wr_ready_q;

    // Next angle/target arrays and the settled flag derived from them.
    always_comb begin
        for (int unsigned n = 0; n < NUM_SERVO; n++) begin
            angle_d[n]  = angle_q[n];
            target_d[n] = target_q[n];
        end
        if (upd_en) begin
            angle_d[upd_idx] = step_next;
        end
        if (wr_accept) begin
            target_d[wr_chan] = clamp_angle(wr_angle);
        end
        settled_d = 1'b1;
        for (int unsigned n = 0; n < NUM_SERVO; n++) begin
            if (angle_d[n] != target_d[n]) begin
                settled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q   <= '{default: RST_A};
            target_q  <= '{default: RST_A};
            settled_q <= 1'b1;
        end else begin
            angle_q   <= angle_d;
            target_q  <= target_d;
            settled_q <= settled_d;
        end
    end

    assign angle1    = angle_q[0];
    assign angle2    = angle_q[1];
    assign angle3    = angle_q[2];
    assign angle4    = angle_q[3];
    assign nextangle = nextangle_q;
    assign wr_ready  = wr_ready_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_servo_angle_slew.sv
// Directed bench for servo_angle_slew with a short frame and a 5-degree step.
module tb_servo_angle_slew;

    localparam int unsigned FRAME = 16;
    localparam int unsigned STEP  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_chan = 2'd0;
    logic [7:0] wr_angle = 8'd0;
    logic [7:0] angle1, angle2, angle3, angle4;
    logic       nextangle;
    logic       settled;

    int n_tests = 0;
    int n_fail  = 0;

    servo_angle_slew #(
        .FRAME_CYCLES (FRAME),
        .STEP         (STEP),
        .RESET_ANGLE  (90)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_chan   (wr_chan),
        .wr_angle  (wr_angle),
        .angle1    (angle1),
        .angle2    (angle2),
        .angle3    (angle3),
        .angle4    (angle4),
        .nextangle (nextangle),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until nextangle is seen (bounded) and check the cycle count.
    task automatic wait_pulse(input string tag, input int exp_ticks);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (nextangle !== 1'b1 && t < 64);
        chk(tag, 32'(t), 32'(exp_ticks));
    endtask

    initial begin
        int e3;
        int e4;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_angle1",    32'(angle1),    32'd90);
        chk("rst_angle2",    32'(angle2),    32'd90);
        chk("rst_angle3",    32'(angle3),    32'd90);
        chk("rst_angle4",    32'(angle4),    32'd90);
        chk("rst_nextangle", 32'(nextangle), 32'd0);
        chk("rst_wr_ready",  32'(wr_ready),  32'd0);
        chk("rst_settled",   32'(settled),   32'd1);

        // 1: idle frames, first strobe 20 edges after release, then every 16
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t1_strobe",  32'(nextangle), (k == 20) ? 32'd1 : 32'd0);
            chk("t1_settled", 32'(settled),   32'd1);
            if (k == 1) chk("t1_ready", 32'(wr_ready), 32'd1);
        end
        tick();
        chk("t1_one_cycle", 32'(nextangle), 32'd0);
        wait_pulse("t1_period", 15);
        chk("t1_angle1", 32'(angle1), 32'd90);
        chk("t1_angle2", 32'(angle2), 32'd90);
        chk("t1_angle3", 32'(angle3), 32'd90);
        chk("t1_angle4", 32'(angle4), 32'd90);

        // 2: ch0 -> 100, write accepted on the PULSE edge
        wr_valid = 1'b1; wr_chan = 2'd0; wr_angle = 8'd100;
        tick();
        wr_valid = 1'b0;
        chk("t2_settled_drop", 32'(settled), 32'd0);
        chk("t2_angle1_hold",  32'(angle1),  32'd90);
        wait_pulse("t2_p1_period", 15);
        chk("t2_p1_angle1",  32'(angle1),  32'd95);
        chk("t2_p1_settled", 32'(settled), 32'd0);
        wait_pulse("t2_p2_period", 16);
        chk("t2_p2_angle1",  32'(angle1),  32'd100);
        chk("t2_p2_settled", 32'(settled), 32'd1);

        // 6: back-to-back writes to ch1 in IDLE, last one wins
        tick();
        chk("t6_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_chan = 2'd1; wr_angle = 8'd60;
        tick();
        wr_angle = 8'd120;
        tick();
        wr_valid = 1'b0;
        wait_pulse("t6_p1_period", 13);
        chk("t6_p1_angle2", 32'(angle2), 32'd95);
        wait_pulse("t6_p2_period", 16);
        chk("t6_p2_angle2", 32'(angle2), 32'd100);

        // 3: ch2 clamped 250 -> 180 ramps up, ch3 -> 0 ramps down
        wr_valid = 1'b1; wr_chan = 2'd2; wr_angle = 8'd250;
        tick();
        wr_chan = 2'd3; wr_angle = 8'd0;
        tick();
        wr_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wait_pulse("t3_period", (i == 1) ? 14 : 16);
            e3 = (90 + 5 * i > 180) ? 180 : 90 + 5 * i;
            e4 = (i >= 18) ? 0 : 90 - 5 * i;
            chk("t3_angle3", 32'(angle3), 32'(e3));
            chk("t3_angle4", 32'(angle4), 32'(e4));
        end
        chk("t3_angle1",  32'(angle1),  32'd100);
        chk("t3_angle2",  32'(angle2),  32'd120);
        chk("t3_settled", 32'(settled), 32'd1);

        // 4: request held through UPD0..UPD3, accepted on PULSE
        repeat (12) tick();
        chk("t4_ready_upd0", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_chan = 2'd0; wr_angle = 8'd20;
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk("t4_ready_upd",   32'(wr_ready), 32'd0);
            chk("t4_settled_upd", 32'(settled),  32'd1);
        end
        tick();
        chk("t4_ready_pulse", 32'(wr_ready),  32'd1);
        chk("t4_pulse",       32'(nextangle), 32'd1);
        chk("t4_angle1_cur",  32'(angle1),    32'd100);
        tick();
        wr_valid = 1'b0;
        chk("t4_ready_idle", 32'(wr_ready), 32'd1);
        chk("t4_settled",    32'(settled),  32'd0);
        wait_pulse("t4_period", 15);
        chk("t4_angle1_next", 32'(angle1), 32'd95);

        // 5: asynchronous reset during UPD2 with ch0 mid-ramp
        wait_pulse("t5_period", 16);
        chk("t5_angle1_pre", 32'(angle1), 32'd90);
        repeat (14) tick();
        chk("t5_angle1_mid", 32'(angle1),    32'd85);
        chk("t5_no_pulse",   32'(nextangle), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_angle1",  32'(angle1),   32'd90);
        chk("t5_async_angle2",  32'(angle2),   32'd90);
        chk("t5_async_angle3",  32'(angle3),   32'd90);
        chk("t5_async_angle4",  32'(angle4),   32'd90);
        chk("t5_async_ready",   32'(wr_ready), 32'd0);
        chk("t5_async_settled", 32'(settled),  32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_pulse("t5_first_pulse", 20);
        chk("t5_angle1_post",  32'(angle1),  32'd90);
        chk("t5_angle3_post",  32'(angle3),  32'd90);
        chk("t5_angle4_post",  32'(angle4),  32'd90);
        chk("t5_settled_post", 32'(settled), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
